// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_subtractor                                            |
// | Description : Bit-serial unsigned subtractor. Computes A - B one bit per   |
// |               clock, LSB first, using a running borrow. The result, the    |
// |               final borrow and a zero flag are registered when the last    |
// |               bit is processed, and they hold until the next completion.   |
// | Ports       : clk    - single clock, rising edge                           |
// |               rst_n  - synchronous active-low reset                        |
// |               start  - begin a subtraction (sampled in IDLE only)          |
// |               A, B   - minuend / subtrahend, captured on start             |
// |               busy   - high while bits are being processed                 |
// |               done   - one-cycle pulse when the result is valid            |
// |               Y      - A - B modulo 2^bits                                 |
// |               borrow - 1 iff A < B (unsigned)                              |
// |               zero   - 1 iff Y == 0                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_subtractor #(
  parameter int bits = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] Y,
  output logic            borrow,
  output logic            zero
);

  // One spare bit so the counter can never wrap for any legal width.
  localparam int CNT_W = $clog2(bits) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [bits-1:0]   a_sh;
  logic [bits-1:0]   b_sh;
  logic [bits-1:0]   res_sh;
  logic [CNT_W-1:0]  cnt;
  logic              br;
  logic [bits-1:0]   y_q;
  logic              borrow_q;
  logic              zero_q;

  logic              a_bit;
  logic              b_bit;
  logic              d_bit;
  logic              br_next;
  logic              last_bit;
  logic [bits-1:0]   res_next;

  // Full-subtractor cell on the current LSBs.
  assign a_bit    = a_sh[0];
  assign b_bit    = b_sh[0];
  assign d_bit    = a_bit ^ b_bit ^ br;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  assign last_bit = (cnt == CNT_W'(bits - 1));
  // Difference bits enter at the MSB so after 'bits' shifts bit 0 sits at the LSB.
  assign res_next = {d_bit, res_sh[bits-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            cnt    <= '0;
            br     <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          br     <= br_next;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            y_q      <= res_next;
            borrow_q <= br_next;
            zero_q   <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign Y      = y_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL provide parameter bits, default 4, operand/result width; legal range bits >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A  input  bits  minuend, unsigned, captured when start is accepted.
REQ-006 SHALL have port B  input  bits  subtrahend, unsigned, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  single-cycle pulse, high only in DONE.
REQ-009 SHALL have port Y  output  bits  registered result, A - B modulo 2^bits.
REQ-010 SHALL have port borrow  output  1  registered final borrow, 1 iff A < B unsigned.
REQ-011 SHALL have port zero  output  1  registered flag, 1 iff result Y == 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE, encoded internally, one-hot or binary at implementer's choice.
REQ-013 IDLE: on edge with start=1, SHALL capture A and B into internal shift registers, clear bit counter and running borrow to 0, go to RUN; start=0 stays in IDLE.
REQ-014 RUN: each edge SHALL process one bit, LSB first: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br); d shifted into result register.
REQ-015 RUN SHALL last exactly bits cycles; on the edge processing bit bits-1, state goes to DONE.
REQ-016 On the RUN->DONE edge, Y, borrow and zero SHALL be loaded from the completed result; they SHALL hold their values at all other times until the next RUN->DONE edge.
REQ-017 DONE SHALL last exactly one cycle and unconditionally return to IDLE; start in DONE is ignored.
REQ-018 Latency: start accepted at edge k gives busy high in cycles k+1..k+bits, done high in cycle k+bits+1, next start acceptable at edge k+bits+2.
REQ-019 start asserted during RUN or DONE SHALL be ignored with no effect on operands, counter or outputs; it is not queued.
REQ-020 Changes on A/B after acceptance SHALL NOT affect the result in progress.
REQ-021 Bit counter SHALL be sized ceil(log2(bits))+1 bits minimum to avoid wrap for any legal bits value.
REQ-022 busy and done SHALL be decoded from state registers (glitch-free, registered-state derived), never both high.

Reset
REQ-023 With rst_n=0 at a rising edge, SHALL enter IDLE and set Y=0, borrow=0, zero=0, busy=0, done=0, counter=0, running borrow=0, regardless of state (including mid-RUN).
REQ-024 Reset SHALL take priority over start; start sampled in the same cycle as rst_n=0 is discarded.
REQ-025 Operation interrupted by reset SHALL produce no done pulse and leave no partial result on Y.

Verification
REQ-026 bits=4, A=9, B=3, start one cycle -> busy for 4 cycles, done pulse in 5th cycle after accepting edge, Y=6, borrow=0, zero=0.
REQ-027 bits=4, A=3, B=9 -> Y=4'hA, borrow=1, zero=0; A=0, B=15 -> Y=1, borrow=1.
REQ-028 bits=4, A=7, B=7 -> Y=0, borrow=0, zero=1; then A=15, B=0 -> Y=15, zero=0, prior outputs held until this DONE edge.
REQ-029 Start held high continuously with A=5, B=2 changing to A=1, B=1 mid-RUN -> exactly one result Y=3 per 6-cycle period (bits+2), no re-trigger inside RUN/DONE.
REQ-030 rst_n=0 for one cycle in 2nd RUN cycle of A=12, B=4 -> busy=0 next cycle, no done, Y/borrow/zero=0; new start then yields Y=8.
REQ-031 Random sweep, bits=8, 10k operand pairs -> Y == (A-B) mod 256, borrow == (A<B), zero == (Y==0) every transaction.
